m_rect_fill: RTL and testbench

- Command-driven rectangle fill engine that writes pixels into the 256x256 video memory (vmem) that the ST7789 display path scans out.
- Sits directly upstream of vmem, in place of the free-running test-pattern writer. It drives the vmem write port (address {y,x}, write enable, 16-bit RGB565 data).
- Accepts one rectangle command per valid/ready handshake and emits exactly one pixel write per clock.
- Used for screen clears, UI boxes and test patterns.

---
 rtl/m_rect_fill_if.sv | 27 ++
 rtl/m_rect_fill.sv | 125 ++++++++++++
 tb/tb_m_rect_fill.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/m_rect_fill_if.sv
// Command and vmem write-port bundle for the rectangle fill engine.
// The master side issues commands and observes the pixel stream; the slave side is the engine.
interface m_rect_fill_if;
  logic        w_cmd_valid;
  logic        w_cmd_ready;
  logic [7:0]  w_cmd_x0;
  logic [7:0]  w_cmd_y0;
  logic [7:0]  w_cmd_x1;
  logic [7:0]  w_cmd_y1;
  logic [15:0] w_cmd_color;
  logic [15:0] w_cmd_color2;
  logic        w_st_we;
  logic [15:0] w_st_wadr;
  logic [15:0] w_st_wdata;
  logic        w_busy;
  logic        w_done;

  modport master (
    output w_cmd_valid, w_cmd_x0, w_cmd_y0, w_cmd_x1, w_cmd_y1, w_cmd_color, w_cmd_color2,
    input  w_cmd_ready, w_st_we, w_st_wadr, w_st_wdata, w_busy, w_done
  );

  modport slave (
    input  w_cmd_valid, w_cmd_x0, w_cmd_y0, w_cmd_x1, w_cmd_y1, w_cmd_color, w_cmd_color2,
    output w_cmd_ready, w_st_we, w_st_wadr, w_st_wdata, w_busy, w_done
  );
endinterface

// File: rtl/m_rect_fill.sv
// Rectangle fill engine: one command in, one raster-ordered vmem write per clock out.
// Define RECT_FILL_CHECKER_EN to alternate color/color2 on CHK_BIT-sized screen tiles.
module m_rect_fill #(
  parameter int WIDTH   = 240,
  parameter int HEIGHT  = 240,
  parameter int CHK_BIT = 3
) (
  input  logic          w_clk,
  input  logic          w_rst_n,
  m_rect_fill_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_e;

  localparam logic [7:0] XMAX = 8'(WIDTH - 1);
  localparam logic [7:0] YMAX = 8'(HEIGHT - 1);

  if (CHK_BIT < 0 || CHK_BIT > 7) begin : g_chk_range
    $error("CHK_BIT must index an 8-bit coordinate");
  end

  state_e      state_q, state_d;
  logic [7:0]  x0_q, y0_q, x1_q, y1_q;
  logic [15:0] col_q;
  logic [7:0]  xl_q, xh_q, yl_q, yh_q;
  logic [7:0]  x_q, y_q;
  logic        we_q, done_q, ready_q;
  logic [15:0] wadr_q, wdata_q;

  logic        accept;
  logic [7:0]  xl_c, xm_c, xh_c, yl_c, ym_c, yh_c;
  logic        empty_c, last_c;
  logic [15:0] pix_c;

  assign accept  = bus.w_cmd_valid && ready_q;
  assign xl_c    = (x0_q < x1_q) ? x0_q : x1_q;
  assign xm_c    = (x0_q < x1_q) ? x1_q : x0_q;
  assign yl_c    = (y0_q < y1_q) ? y0_q : y1_q;
  assign ym_c    = (y0_q < y1_q) ? y1_q : y0_q;
  assign xh_c    = (xm_c > XMAX) ? XMAX : xm_c;
  assign yh_c    = (ym_c > YMAX) ? YMAX : ym_c;
  assign empty_c = (xl_c > XMAX) || (yl_c > YMAX);
  assign last_c  = (x_q == xh_q) && (y_q == yh_q);

`ifdef RECT_FILL_CHECKER_EN
  logic [15:0] col2_q;
  always_ff @(posedge w_clk) begin
    if (!w_rst_n)    col2_q <= '0;
    else if (accept) col2_q <= bus.w_cmd_color2;
  end
  assign pix_c = (x_q[CHK_BIT] ^ y_q[CHK_BIT]) ? col2_q : col_q;
`else
  assign pix_c = col_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = empty_c ? DONE : FILL;
      FILL:    if (last_c) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs trail the state by one register stage; ready is also held low
  // through the done pulse so a new command never overlaps it.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      wadr_q  <= '0;
      wdata_q <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      col_q   <= '0;
      xl_q    <= '0;
      xh_q    <= '0;
      yl_q    <= '0;
      yh_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE) && (state_q != DONE);
      we_q    <= (state_q == FILL);
      done_q  <= (state_q == DONE);
      if (accept) begin
        x0_q  <= bus.w_cmd_x0;
        y0_q  <= bus.w_cmd_y0;
        x1_q  <= bus.w_cmd_x1;
        y1_q  <= bus.w_cmd_y1;
        col_q <= bus.w_cmd_color;
      end
      if (state_q == LOAD) begin
        xl_q <= xl_c;
        xh_q <= xh_c;
        yl_q <= yl_c;
        yh_q <= yh_c;
        x_q  <= xl_c;
        y_q  <= yl_c;
      end
      if (state_q == FILL) begin
        wadr_q  <= {y_q, x_q};
        wdata_q <= pix_c;
        if (x_q == xh_q) begin
          x_q <= xl_q;
          y_q <= y_q + 8'd1;
        end else begin
          x_q <= x_q + 8'd1;
        end
      end
    end
  end

  assign bus.w_cmd_ready = ready_q;
  assign bus.w_busy      = !ready_q;
  assign bus.w_st_we     = we_q;
  assign bus.w_st_wadr   = wadr_q;
  assign bus.w_st_wdata  = wdata_q;
  assign bus.w_done      = done_q;
endmodule

// File: tb/tb_m_rect_fill.sv
// Directed bench for m_rect_fill: vector table of rectangles plus back-pressure and reset-abort sequences.
module tb_m_rect_fill;
  logic w_clk = 1'b0;
  logic w_rst_n = 1'b0;
  m_rect_fill_if bus();

  m_rect_fill #(.WIDTH(240), .HEIGHT(240), .CHK_BIT(3)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .bus(bus)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    int          e;
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [7:0]  x0, y0, x1, y1;
    logic [15:0] c, c2;
    int          xl, xh, yl, yh;
    bit          empty;
  } vec_t;

  int   edge_n = 0;
  int   rdy_rise = -1;
  logic prev_rdy = 1'b1;
  wr_t  wq[$];
  int   done_q[$];
  int   acc_q[$];
  int   errs = 0;
  int   checks = 0;

  always @(posedge w_clk) begin
    edge_n = edge_n + 1;
    if (bus.w_cmd_valid && bus.w_cmd_ready && w_rst_n) acc_q.push_back(edge_n);
    #1;
    if (bus.w_st_we) wq.push_back('{edge_n, bus.w_st_wadr, bus.w_st_wdata});
    if (bus.w_done) done_q.push_back(edge_n);
    if (bus.w_cmd_ready && !prev_rdy) rdy_rise = edge_n;
    prev_rdy = bus.w_cmd_ready;
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  function automatic logic [15:0] exp_px(input int x, input int y, input logic [15:0] c, input logic [15:0] c2);
`ifdef RECT_FILL_CHECKER_EN
    return (((x >> 3) ^ (y >> 3)) & 1) ? c2 : c;
`else
    return c;
`endif
  endfunction

  task automatic clear_mon();
    wq.delete();
    done_q.delete();
    acc_q.delete();
    rdy_rise = -1;
  endtask

  task automatic set_cmd(input logic [7:0] x0, y0, x1, y1, input logic [15:0] c, c2);
    bus.w_cmd_x0 = x0; bus.w_cmd_y0 = y0; bus.w_cmd_x1 = x1; bus.w_cmd_y1 = y1;
    bus.w_cmd_color = c; bus.w_cmd_color2 = c2;
  endtask

  // Presents one command, returns its accept edge number and drops valid afterwards.
  task automatic issue(input vec_t v, output int k);
    int t = 0;
    @(negedge w_clk);
    while (!bus.w_cmd_ready && t < 200) begin @(negedge w_clk); t++; end
    if (!bus.w_cmd_ready) chk("ready_timeout", 0, 1);
    set_cmd(v.x0, v.y0, v.x1, v.y1, v.c, v.c2);
    bus.w_cmd_valid = 1'b1;
    k = edge_n + 1;
    @(negedge w_clk);
    bus.w_cmd_valid = 1'b0;
  endtask

  // Compares wq[base..] against the raster walk of a rectangle starting at edge k+2.
  task automatic check_seq(input string nm, input int base, input int k, input int xl, xh, yl, yh,
                           input logic [15:0] c, c2);
    int bad_a = 0, bad_d = 0, bad_e = 0, i = base;
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++) begin
        if (i < wq.size()) begin
          if (wq[i].a !== 16'((y << 8) | x)) bad_a++;
          if (wq[i].d !== exp_px(x, y, c, c2)) bad_d++;
          if (wq[i].e != k + 2 + (i - base)) bad_e++;
        end
        i++;
      end
    chk({nm, "_addr_seq"}, bad_a, 0);
    chk({nm, "_data_seq"}, bad_d, 0);
    chk({nm, "_timing_seq"}, bad_e, 0);
  endtask

  vec_t vecs[8];

  initial begin
    int k, n, k2;
    int t;
    bit seen;
    logic [31:0] r;

    vecs[0] = '{8'd0,   8'd0,   8'd239, 8'd239, 16'h0000, 16'h0000, 0,   239, 0,   239, 1'b0};
    vecs[1] = '{8'd10,  8'd3,   8'd5,   8'd3,   16'hF800, 16'h0000, 5,   10,  3,   3,   1'b0};
    vecs[2] = '{8'd230, 8'd0,   8'd250, 8'd0,   16'h07E0, 16'h0000, 230, 239, 0,   0,   1'b0};
    vecs[3] = '{8'd245, 8'd0,   8'd245, 8'd0,   16'h1111, 16'h2222, 0,   0,   0,   0,   1'b1};
    vecs[4] = '{8'd3,   8'd250, 8'd2,   8'd238, 16'h1234, 16'h4321, 2,   3,   238, 239, 1'b0};
    vecs[5] = '{8'd0,   8'd240, 8'd1,   8'd255, 16'h3333, 16'h4444, 0,   0,   0,   0,   1'b1};
    vecs[6] = '{8'd0,   8'd0,   8'd15,  8'd0,   16'hFFFF, 16'h001F, 0,   15,  0,   0,   1'b0};
    vecs[7] = '{8'd239, 8'd239, 8'd239, 8'd239, 16'hA5A5, 16'h5A5A, 239, 239, 239, 239, 1'b0};

    bus.w_cmd_valid = 1'b0;
    set_cmd(8'd0, 8'd0, 8'd0, 8'd0, 16'h0000, 16'h0000);
    repeat (3) @(negedge w_clk);
    chk("rst_ready", bus.w_cmd_ready, 1);
    chk("rst_busy",  bus.w_busy, 0);
    chk("rst_we",    bus.w_st_we, 0);
    chk("rst_wadr",  bus.w_st_wadr, 0);
    chk("rst_wdata", bus.w_st_wdata, 0);
    chk("rst_done",  bus.w_done, 0);
    w_rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      clear_mon();
      n = vecs[v].empty ? 0 : (vecs[v].xh - vecs[v].xl + 1) * (vecs[v].yh - vecs[v].yl + 1);
      issue(vecs[v], k);
      @(negedge w_clk);
      chk($sformatf("v%0d_busy", v), bus.w_busy, 1);
      repeat (n + 8) @(negedge w_clk);
      chk($sformatf("v%0d_writes", v), wq.size(), n);
      if (n > 0) begin
        check_seq($sformatf("v%0d", v), 0, k, vecs[v].xl, vecs[v].xh, vecs[v].yl, vecs[v].yh,
                  vecs[v].c, vecs[v].c2);
        chk($sformatf("v%0d_first_adr", v), wq[0].a, (vecs[v].yl << 8) | vecs[v].xl);
        chk($sformatf("v%0d_last_adr", v), wq[wq.size()-1].a, (vecs[v].yh << 8) | vecs[v].xh);
      end
      chk($sformatf("v%0d_done_cnt", v), done_q.size(), 1);
      chk($sformatf("v%0d_done_edge", v), (done_q.size() > 0) ? done_q[0] - k : -1, n + 2);
      chk($sformatf("v%0d_ready_back", v), rdy_rise - k, n + 3);
      chk($sformatf("v%0d_we_idle", v), bus.w_st_we, 0);
      if (v == 0 && wq.size() > 240) begin
        chk("clear_row_end", wq[239].a, 16'h00EF);
        chk("clear_row_next", wq[240].a, 16'h0100);
        chk("clear_last", wq[wq.size()-1].a, 16'hEFEF);
      end
      if (v == 6 && wq.size() > 8) begin
        chk("chk_x7", wq[7].d, 16'hFFFF);
`ifdef RECT_FILL_CHECKER_EN
        chk("chk_x8", wq[8].d, 16'h001F);
`else
        chk("chk_x8", wq[8].d, 16'hFFFF);
`endif
      end
    end

    // Valid held high with changing fields through a 4x4 fill, then a 1-pixel follow-up.
    clear_mon();
    @(negedge w_clk);
    set_cmd(8'd23, 8'd43, 8'd20, 8'd40, 16'h1234, 16'h00FF);
    bus.w_cmd_valid = 1'b1;
    for (int i = 0; i < 80 && acc_q.size() < 2; i++) begin
      @(negedge w_clk);
      if (acc_q.size() == 1) begin
        if (done_q.size() == 0) begin
          r = $urandom;
          set_cmd(r[7:0], r[15:8], r[23:16], r[31:24], r[15:0], r[31:16]);
        end else begin
          set_cmd(8'd100, 8'd100, 8'd100, 8'd100, 16'hABCD, 16'hDCBA);
        end
      end
    end
    bus.w_cmd_valid = 1'b0;
    repeat (10) @(negedge w_clk);
    chk("bp_accepts", acc_q.size(), 2);
    if (acc_q.size() == 2 && done_q.size() > 0) begin
      k = acc_q[0];
      k2 = acc_q[1];
      chk("bp_writes", wq.size(), 17);
      check_seq("bp_first", 0, k, 20, 23, 40, 43, 16'h1234, 16'h00FF);
      chk("bp_gap", k2 - k, 16 + 4);
      chk("bp_after_done", (k2 > done_q[0]) ? 1 : 0, 1);
      check_seq("bp_second", 16, k2, 100, 100, 100, 100, 16'hABCD, 16'hDCBA);
      chk("bp_done_cnt", done_q.size(), 2);
    end

    // Reset asserted for one edge once the fifth pixel of a 16-pixel fill is out.
    clear_mon();
    issue('{8'd0, 8'd5, 8'd15, 8'd5, 16'h5555, 16'hAAAA, 0, 15, 5, 5, 1'b0}, k);
    seen = 1'b0;
    for (t = 0; t < 30 && !seen; t++) begin
      if (wq.size() >= 5) seen = 1'b1;
      else @(negedge w_clk);
    end
    chk("rmf_reached_px5", wq.size(), 5);
    w_rst_n = 1'b0;
    @(negedge w_clk);
    w_rst_n = 1'b1;
    chk("rmf_we", bus.w_st_we, 0);
    chk("rmf_ready", bus.w_cmd_ready, 1);
    chk("rmf_busy", bus.w_busy, 0);
    repeat (25) @(negedge w_clk);
    chk("rmf_writes", wq.size(), 5);
    chk("rmf_no_done", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
